// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset/bubble constants, the IF/ID register layout
// and the fetch-stage FSM states.
package pipe_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    // MIPS sll $0,$0,0 -- the canonical no-op used for bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        REDIRECT
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
// Priority: reset > flush > load > hold.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  pipe_pkg::if_id_t d,
    output pipe_pkg::if_id_t q
);

    import pipe_pkg::*;

    // Flush loads the constant bubble so nothing from imem_rdata leaks in.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q.pc    <= 32'h0000_0000;
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture,
// branch redirect with wrong-path squash, stall handling and fetch counter.
module if_stage_pc_unit #(
    parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      pc_branch_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_if_id,
    output logic [31:0]      instr_if_id,
    output logic             valid_if_id,
    output logic             redirect,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    import pipe_pkg::*;

    logic [31:0]  pc_q;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    fetch_state_e state_q;
    fetch_state_e state_next;
    logic         ifid_load;
    logic         ifid_flush;
    logic         count_inc;
    logic         misalign_set;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_plus4 = pc_q + 32'd4;

    // Branch beats stall: a stalled instruction after a taken branch is wrong-path.
    always_comb begin
        pc_next      = pc_q;
        state_next   = RUN;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        count_inc    = 1'b0;
        misalign_set = 1'b0;
        if (branch_taken) begin
            pc_next      = {pc_branch_target[31:2], 2'b00};
            ifid_flush   = 1'b1;
            state_next   = REDIRECT;
            misalign_set = |pc_branch_target[1:0];
        end else if (stall) begin
            state_next   = HOLD;
        end else begin
            pc_next      = pc_plus4;
            ifid_load    = 1'b1;
            count_inc    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            state_q      <= RUN;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            pc_q    <= pc_next;
            state_q <= state_next;
            if (misalign_set) begin
                misalign_err <= 1'b1;
            end
            if (count_inc) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

    assign ifid_d = '{pc: pc_plus4, instr: imem_rdata, valid: 1'b1};

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr   = pc_q;
    assign pc_if_id    = ifid_q.pc;
    assign instr_if_id = ifid_q.instr;
    assign valid_if_id = ifid_q.valid;
    assign redirect    = (state_q == REDIRECT);

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Directed bench for if_stage_pc_unit: sequential fetch, redirect, stall,
// stall+branch, back-to-back branches, misalignment, reset and PC wrap.
module tb_if_stage_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] pc_branch_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc_if_id;
    logic [31:0] instr_if_id;
    logic        valid_if_id;
    logic        redirect;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_checks;
    int n_fail;

    if_stage_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .pc_branch_target (pc_branch_target),
        .imem_rdata       (imem_rdata),
        .imem_addr        (imem_addr),
        .pc_if_id         (pc_if_id),
        .instr_if_id      (instr_if_id),
        .valid_if_id      (valid_if_id),
        .redirect         (redirect),
        .misalign_err     (misalign_err),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address A is 0x2008_0000 + A[15:2] + 1
    assign imem_rdata = 32'h2008_0000 + {18'd0, imem_addr[15:2]} + 32'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step,
                             input logic [31:0] e_addr, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic e_valid,
                             input logic e_redir, input logic e_mis,
                             input logic [31:0] e_cnt);
        check({step, ".imem_addr"},    imem_addr,             e_addr);
        check({step, ".pc_if_id"},     pc_if_id,              e_pc);
        check({step, ".instr_if_id"},  instr_if_id,           e_instr);
        check({step, ".valid_if_id"},  {31'd0, valid_if_id},  {31'd0, e_valid});
        check({step, ".redirect"},     {31'd0, redirect},     {31'd0, e_redir});
        check({step, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e_mis});
        check({step, ".fetch_count"},  fetch_count,           e_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; pc_branch_target = 32'h0;

        tick();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        // Free-running sequential fetch
        tick(); check_all("seq1", 32'h04, 32'h04, 32'h2008_0001, 1'b1, 1'b0, 1'b0, 32'd1);
        tick(); check_all("seq2", 32'h08, 32'h08, 32'h2008_0002, 1'b1, 1'b0, 1'b0, 32'd2);
        tick(); check_all("seq3", 32'h0C, 32'h0C, 32'h2008_0003, 1'b1, 1'b0, 1'b0, 32'd3);
        tick(); check_all("seq4", 32'h10, 32'h10, 32'h2008_0004, 1'b1, 1'b0, 1'b0, 32'd4);

        // Taken branch at PC 0x10 to 0x40
        branch_taken = 1'b1; pc_branch_target = 32'h40;
        tick(); check_all("br40", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd4);
        branch_taken = 1'b0;
        tick(); check_all("br40_tgt", 32'h44, 32'h44, 32'h2008_0011, 1'b1, 1'b0, 1'b0, 32'd5);

        // Move to PC 0x8 with a valid instruction in IF/ID, then stall 3 cycles
        branch_taken = 1'b1; pc_branch_target = 32'h04;
        tick(); check_all("br04", 32'h04, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd5);
        branch_taken = 1'b0;
        tick(); check_all("pre_stall", 32'h08, 32'h08, 32'h2008_0002, 1'b1, 1'b0, 1'b0, 32'd6);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("stall", 32'h08, 32'h08, 32'h2008_0002, 1'b1, 1'b0, 1'b0, 32'd6);
        end
        stall = 1'b0;
        tick(); check_all("unstall", 32'h0C, 32'h0C, 32'h2008_0003, 1'b1, 1'b0, 1'b0, 32'd7);

        // Stall and branch together: branch wins
        stall = 1'b1; branch_taken = 1'b1; pc_branch_target = 32'h100;
        tick(); check_all("stall_br", 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd7);
        stall = 1'b0; pc_branch_target = 32'h200;
        tick(); check_all("b2b_br", 32'h200, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd7);

        // Misaligned target: low bits dropped, sticky error
        pc_branch_target = 32'h102;
        tick(); check_all("mis_br", 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd7);
        branch_taken = 1'b0;
        tick(); check_all("mis_seq1", 32'h104, 32'h104, 32'h2008_0041, 1'b1, 1'b0, 1'b1, 32'd8);
        tick(); check_all("mis_seq2", 32'h108, 32'h108, 32'h2008_0042, 1'b1, 1'b0, 1'b1, 32'd9);

        // Reset while a redirect is in progress and branch/stall still asserted
        branch_taken = 1'b1; pc_branch_target = 32'h40;
        tick(); check_all("pre_rst_br", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd9);
        reset = 1'b1; stall = 1'b1;
        tick(); check_all("rst_mid_br", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;

        // PC wrap at 0xFFFF_FFFC
        branch_taken = 1'b1; pc_branch_target = 32'hFFFF_FFFC;
        tick(); check_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);
        branch_taken = 1'b0;
        tick(); check_all("wrap", 32'h0, 32'h0, 32'h2008_4000, 1'b1, 1'b0, 1'b0, 32'd1);
        tick(); check_all("post_wrap", 32'h04, 32'h04, 32'h2008_0001, 1'b1, 1'b0, 1'b0, 32'd2);
        reset = 1'b1;
        tick(); check_all("rst_run", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
